// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, twiddle ROM, state encoding and bit reversal for the 16-point FFT blocks
package fft_pkg;
  localparam int N = 16;
  localparam int STAGES = 4;
  localparam int TW_W = 16;
  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
  localparam logic signed [TW_W-1:0] TW_COS [N/2] = '{
    16'sd256, 16'sd237, 16'sd181, 16'sd98, 16'sd0, -16'sd98, -16'sd181, -16'sd237};
  localparam logic signed [TW_W-1:0] TW_SIN [N/2] = '{
    16'sd0, 16'sd98, 16'sd181, 16'sd237, 16'sd256, 16'sd237, 16'sd181, 16'sd98};
  function automatic logic [3:0] bitrev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction
endpackage

// File: rtl/ifft_butterfly.sv
// ifft_butterfly: combinational inverse radix-2 butterfly; define IFFT_SCALE_EN to halve each result
module ifft_butterfly #(
  parameter int DATA_WIDTH = 16,
  parameter int F_POINT = 8,
  parameter int TW_W = 16
) (
  input  logic signed [DATA_WIDTH-1:0] a_r,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_r,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic signed [TW_W-1:0]       w_r,
  input  logic signed [TW_W-1:0]       w_i,
  output logic signed [DATA_WIDTH-1:0] top_r,
  output logic signed [DATA_WIDTH-1:0] top_i,
  output logic signed [DATA_WIDTH-1:0] bot_r,
  output logic signed [DATA_WIDTH-1:0] bot_i
);
  localparam int MW = DATA_WIDTH + TW_W;
  localparam int PW = MW + 1;
`ifdef IFFT_SCALE_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif
  logic signed [MW-1:0] rr, ii, ri, ir;
  logic signed [PW-1:0] p_r, p_i;
  logic signed [PW:0] t_r, t_i, u_r, u_i;
  assign rr = MW'(b_r) * MW'(w_r);
  assign ii = MW'(b_i) * MW'(w_i);
  assign ri = MW'(b_r) * MW'(w_i);
  assign ir = MW'(b_i) * MW'(w_r);
  assign p_r = (PW'(rr) - PW'(ii)) >>> F_POINT;
  assign p_i = (PW'(ri) + PW'(ir)) >>> F_POINT;
  assign t_r = (PW+1)'(a_r) + (PW+1)'(p_r);
  assign t_i = (PW+1)'(a_i) + (PW+1)'(p_i);
  assign u_r = (PW+1)'(a_r) - (PW+1)'(p_r);
  assign u_i = (PW+1)'(a_i) - (PW+1)'(p_i);
  assign top_r = DATA_WIDTH'(t_r >>> SH);
  assign top_i = DATA_WIDTH'(t_i >>> SH);
  assign bot_r = DATA_WIDTH'(u_r >>> SH);
  assign bot_i = DATA_WIDTH'(u_i >>> SH);
endmodule

// File: rtl/ifft_16_seq.sv
// ifft_16_seq: sequential 16-point radix-2 DIT inverse FFT; define IFFT_SCALE_EN for 1/2 scaling per stage
module ifft_16_seq
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int F_POINT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic                  out_last,
  output logic                  busy
);
  localparam logic [3:0] LAST = 4'(N - 1);
  state_t state_q, state_d;
  logic [3:0] n_q, m_q;
  logic [4:0] c_q;
  logic signed [DATA_WIDTH-1:0] mem_r [N];
  logic signed [DATA_WIDTH-1:0] mem_i [N];
  logic [1:0] s;
  logic [2:0] k, t;
  logic [3:0] span, j, top, bot;
  logic signed [DATA_WIDTH-1:0] top_r, top_i, bot_r, bot_i;
  logic in_fire, out_fire;
  assign in_ready = state_q == LOAD;
  assign busy = state_q != LOAD;
  assign out_valid = state_q == UNLOAD;
  assign out_last = out_valid && m_q == LAST;
  assign out_r = out_valid ? mem_r[m_q] : '0;
  assign out_i = out_valid ? mem_i[m_q] : '0;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // butterfly addresses and twiddle index from stage s = c[4:3], butterfly k = c[2:0]
  always_comb begin
    s = c_q[4:3];
    k = c_q[2:0];
    span = 4'd1 << s;
    j = {1'b0, k} & (span - 4'd1);
    top = (({1'b0, k} >> s) << (3'(s) + 3'd1)) + j;
    bot = top + span;
    t = 3'(j << (2'd3 - s));
  end
  ifft_butterfly #(.DATA_WIDTH(DATA_WIDTH), .F_POINT(F_POINT), .TW_W(TW_W)) u_bf (
    .a_r(mem_r[top]), .a_i(mem_i[top]), .b_r(mem_r[bot]), .b_i(mem_i[bot]),
    .w_r(TW_COS[t]), .w_i(TW_SIN[t]),
    .top_r(top_r), .top_i(top_i), .bot_r(bot_r), .bot_i(bot_i)
  );
  // next state: 16 load beats, 32 butterfly cycles, 16 unload beats
  always_comb begin
    state_d = state_q;
    if (state_q == LOAD && in_fire && n_q == LAST) state_d = COMPUTE;
    if (state_q == COMPUTE && &c_q) state_d = UNLOAD;
    if (state_q == UNLOAD && out_fire && m_q == LAST) state_d = LOAD;
  end
  // state register and the three frame counters; counters wrap back to 0 at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      n_q <= '0;
      c_q <= '0;
      m_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) n_q <= n_q + 4'd1;
      if (state_q == COMPUTE) c_q <= c_q + 5'd1;
      if (out_fire) m_q <= m_q + 4'd1;
    end
  end
  // frame buffer: loaded in bit-reversed order, then updated in place by the butterfly
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_r[bitrev4(n_q)] <= in_r;
      mem_i[bitrev4(n_q)] <= in_i;
    end else if (state_q == COMPUTE) begin
      mem_r[top] <= top_r;
      mem_i[top] <= top_i;
      mem_r[bot] <= bot_r;
      mem_i[bot] <= bot_i;
    end
  end
endmodule

// File: tb/tb_ifft_16_seq.sv
// tb_ifft_16_seq: scoreboard bench for ifft_16_seq against a loop-based fixed-point IFFT model and an ideal DFT
module tb_ifft_16_seq;
`ifdef IFFT_SCALE_EN
  localparam int SH = 1;
  localparam real TOL = 3.0;
`else
  localparam int SH = 0;
  localparam real TOL = 6.0;
`endif
  localparam real PI = 3.14159265358979;
  typedef struct {
    logic [15:0] r;
    logic [15:0] i;
    logic        last;
    bit          ideal;
    real         ir;
    real         ii;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [15:0] in_r = '0;
  logic [15:0] in_i = '0;
  logic in_ready, out_valid, out_last, busy;
  logic [15:0] out_r, out_i;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  bit rand_ready = 0;
  int xr[16], xi[16];
  longint ar[16], ai[16];
  ifft_16_seq #(.DATA_WIDTH(16), .F_POINT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
    .out_last(out_last), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic longint q16(input longint v);
    shortint w;
    w = shortint'(v);
    return longint'(w);
  endfunction
  function automatic longint tw(input int t, input bit sn);
    real a, v;
    a = 2.0 * PI * t / 16.0;
    v = (sn ? $sin(a) : $cos(a)) * 256.0;
    return longint'($rtoi(v + (v >= 0.0 ? 0.5 : -0.5)));
  endfunction
  function automatic int rev4(input int n);
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) if (n & (1 << b)) r |= 8 >> b;
    return r;
  endfunction
  // run the fixed-point model on xr/xi and queue the 16 expected output beats
  task automatic push_expect(input bit ideal);
    int span, a, b, t;
    longint wr, wi, pr, pi;
    real re, im, ang;
    exp_t e;
    for (int n = 0; n < 16; n++) begin
      ar[rev4(n)] = xr[n];
      ai[rev4(n)] = xi[n];
    end
    for (int st = 0; st < 4; st++) begin
      span = 1 << st;
      for (int base = 0; base < 16; base += 2 * span)
        for (int jj = 0; jj < span; jj++) begin
          t = jj * (8 / span);
          wr = tw(t, 0);
          wi = tw(t, 1);
          a = base + jj;
          b = a + span;
          pr = (ar[b] * wr - ai[b] * wi) >>> 8;
          pi = (ar[b] * wi + ai[b] * wr) >>> 8;
          ar[b] = q16((ar[a] - pr) >>> SH);
          ai[b] = q16((ai[a] - pi) >>> SH);
          ar[a] = q16((ar[a] + pr) >>> SH);
          ai[a] = q16((ai[a] + pi) >>> SH);
        end
    end
    for (int n = 0; n < 16; n++) begin
      re = 0.0;
      im = 0.0;
      for (int kk = 0; kk < 16; kk++) begin
        ang = 2.0 * PI * kk * n / 16.0;
        re += xr[kk] * $cos(ang) - xi[kk] * $sin(ang);
        im += xr[kk] * $sin(ang) + xi[kk] * $cos(ang);
      end
      e.r = 16'(ar[n]);
      e.i = 16'(ai[n]);
      e.last = n == 15;
      e.ideal = ideal;
      e.ir = SH == 1 ? re / 16.0 : re;
      e.ii = SH == 1 ? im / 16.0 : im;
      sb.push_back(e);
    end
  endtask
  task automatic send(input bit gaps);
    int w;
    for (int n = 0; n < 16; n++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_r = 16'(xr[n]);
      in_i = 16'(xi[n]);
      w = 0;
      while (!in_ready && w < 100) begin
        @(posedge clk);
        #1;
        w++;
      end
      if (w == 100) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got in_ready=%b expected 1", in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask
  task automatic wait_done();
    int w;
    w = 0;
    while ((sb.size() != 0 || busy) && w < 3000) begin
      @(posedge clk);
      #1;
      w++;
    end
    checks++;
    if (w == 3000) begin
      errors++;
      $display("FAIL frame_timeout: got %0d pending beats busy=%b expected 0 and 0", sb.size(), busy);
      sb.delete();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_after_frame: got %b expected 0", out_valid);
    end
  endtask
  task automatic clear_frame();
    for (int n = 0; n < 16; n++) begin
      xr[n] = 0;
      xi[n] = 0;
    end
  endtask
  task automatic rand_frame();
    for (int n = 0; n < 16; n++) begin
      xr[n] = int'(shortint'($urandom));
      xi[n] = int'(shortint'($urandom));
    end
  endtask
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // downstream ready: always high, or random while rand_ready is set
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  // monitor: pops the scoreboard on each output beat and checks stall stability
  initial begin
    bit stalled;
    logic [15:0] h_r, h_i;
    logic h_l;
    exp_t e;
    real dr, di;
    stalled = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
      end else begin
        if (busy) begin
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_while_busy: got %b expected 0", in_ready);
          end
        end
        if (stalled) begin
          checks++;
          if (out_valid !== 1'b1 || out_r !== h_r || out_i !== h_i || out_last !== h_l) begin
            errors++;
            $display("FAIL stall_hold: got v=%b %h %h l=%b expected v=1 %h %h l=%b",
                     out_valid, out_r, out_i, out_last, h_r, h_i, h_l);
          end
        end
        stalled = out_valid && !out_ready;
        h_r = out_r;
        h_i = out_i;
        h_l = out_last;
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got %h %h expected no beat", out_r, out_i);
          end else begin
            e = sb.pop_front();
            if (out_r !== e.r || out_i !== e.i || out_last !== e.last) begin
              errors++;
              $display("FAIL beat_data: got %h %h last=%b expected %h %h last=%b",
                       out_r, out_i, out_last, e.r, e.i, e.last);
            end
            if (e.ideal) begin
              checks++;
              dr = $itor($signed(out_r)) - e.ir;
              di = $itor($signed(out_i)) - e.ii;
              if (dr > TOL || dr < -TOL || di > TOL || di < -TOL) begin
                errors++;
                $display("FAIL ideal_dft: got %0d %0d expected %0.1f %0.1f", $signed(out_r), $signed(out_i), e.ir, e.ii);
              end
            end
          end
        end
      end
    end
  end
  initial begin
    int amp;
    int sr[16], si[16];
    amp = SH == 1 ? 4096 : 256;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 16'(in_ready), 16'd1);
    chk("reset_out_valid", 16'(out_valid), 16'd0);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_out_last", 16'(out_last), 16'd0);
    chk("reset_out_r", out_r, 16'h0000);
    chk("reset_out_i", out_i, 16'h0000);
    rst = 1'b0;
    clear_frame();
    xr[0] = amp;
    push_expect(1);
    send(0);
    wait_done();
    for (int n = 0; n < 16; n++) xr[n] = 256;
    push_expect(1);
    send(0);
    wait_done();
    clear_frame();
    xr[1] = amp;
    push_expect(1);
    send(0);
    wait_done();
    for (int f = 0; f < 4; f++) begin
      rand_frame();
      sr = xr;
      si = xi;
      rand_ready = 0;
      push_expect(0);
      send(0);
      wait_done();
      xr = sr;
      xi = si;
      rand_ready = 1;
      push_expect(0);
      send(1);
      wait_done();
    end
    rand_ready = 0;
    rand_frame();
    send(0);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset_busy", 16'(busy), 16'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset_in_ready", 16'(in_ready), 16'd1);
    chk("mid_reset_out_valid", 16'(out_valid), 16'd0);
    chk("mid_reset_busy", 16'(busy), 16'd0);
    chk("mid_reset_out_r", out_r, 16'h0000);
    rst = 1'b0;
    clear_frame();
    xr[0] = amp;
    push_expect(1);
    send(0);
    wait_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
